servo_cmd_decoder: RTL and testbench

SERVO_CMD_DECODER -- requirements
Module: servo_cmd_decoder

---
 rtl/servo_cmd_decoder.sv | 148 ++++++++++++++
 tb/tb_servo_cmd_decoder.sv | 337 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/servo_cmd_decoder.sv
// Servo command decoder: assembles {index, pulse_hi, pulse_lo} SPI byte frames
// into clamped per-channel pulse widths, with timeout and deselect abort.
module servo_cmd_decoder #(
  parameter int unsigned NUM_CHANNELS  = 2,
  parameter int unsigned MIN_PULSE     = 500,
  parameter int unsigned MAX_PULSE     = 2500,
  parameter int unsigned DEFAULT_PULSE = 1500,
  parameter int unsigned TIMEOUT_CLKS  = 16000
) (
  input  logic                       i_clock,
  input  logic                       i_reset,
  input  logic                       i_byte_valid,
  input  logic [7:0]                 i_byte,
  input  logic                       i_select,
  output logic [16*NUM_CHANNELS-1:0] o_pulse,
  output logic [NUM_CHANNELS-1:0]    o_update,
  output logic                       o_frame_error,
  output logic [7:0]                 o_error_count,
  output logic                       o_busy
);

  localparam int unsigned CNT_W = $clog2(TIMEOUT_CLKS + 1);

  typedef enum logic [1:0] {IDLE, GET_HI, GET_LO, COMMIT} state_e;

  state_e                         state_q, state_d;
  logic [7:0]                     idx_q, idx_d;
  logic [15:0]                    val_q, val_d;
  logic [CNT_W-1:0]               tmo_q, tmo_d;
  logic [NUM_CHANNELS-1:0][15:0]  pulse_q, pulse_d;
  logic [NUM_CHANNELS-1:0]        update_q, update_d;
  logic                           ferr_q, ferr_d;
  logic [7:0]                     errcnt_q, errcnt_d;
  logic                           busy_q, busy_d;
  logic                           sel_meta_q, sel_sync_q, sel_prev_q;
  logic                           deselect_c;
  logic [15:0]                    clamped_c;

  assign deselect_c = sel_sync_q & ~sel_prev_q;

  assign clamped_c = (val_q < 16'(MIN_PULSE)) ? 16'(MIN_PULSE) :
                     (val_q > 16'(MAX_PULSE)) ? 16'(MAX_PULSE) : val_q;

  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      state_q    <= IDLE;
      idx_q      <= '0;
      val_q      <= '0;
      tmo_q      <= '0;
      pulse_q    <= {NUM_CHANNELS{16'(DEFAULT_PULSE)}};
      update_q   <= '0;
      ferr_q     <= 1'b0;
      errcnt_q   <= '0;
      busy_q     <= 1'b0;
      sel_meta_q <= 1'b1;
      sel_sync_q <= 1'b1;
      sel_prev_q <= 1'b1;
    end else begin
      state_q    <= state_d;
      idx_q      <= idx_d;
      val_q      <= val_d;
      tmo_q      <= tmo_d;
      pulse_q    <= pulse_d;
      update_q   <= update_d;
      ferr_q     <= ferr_d;
      errcnt_q   <= errcnt_d;
      busy_q     <= busy_d;
      sel_meta_q <= i_select;
      sel_sync_q <= sel_meta_q;
      sel_prev_q <= sel_sync_q;
    end
  end

  // Frame assembly; a byte arriving on the timeout cycle still counts as on time.
  always_comb begin
    state_d  = state_q;
    idx_d    = idx_q;
    val_d    = val_q;
    tmo_d    = '0;
    pulse_d  = pulse_q;
    update_d = '0;
    ferr_d   = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (i_byte_valid) begin
          idx_d   = i_byte;
          state_d = GET_HI;
        end
      end
      GET_HI: begin
        if (deselect_c) begin
          state_d = IDLE;
          ferr_d  = 1'b1;
        end else if (i_byte_valid) begin
          val_d[15:8] = i_byte;
          state_d     = GET_LO;
        end else if (tmo_q == CNT_W'(TIMEOUT_CLKS - 1)) begin
          state_d = IDLE;
          ferr_d  = 1'b1;
        end else begin
          tmo_d = tmo_q + CNT_W'(1);
        end
      end
      GET_LO: begin
        if (deselect_c) begin
          state_d = IDLE;
          ferr_d  = 1'b1;
        end else if (i_byte_valid) begin
          val_d[7:0] = i_byte;
          state_d    = COMMIT;
        end else if (tmo_q == CNT_W'(TIMEOUT_CLKS - 1)) begin
          state_d = IDLE;
          ferr_d  = 1'b1;
        end else begin
          tmo_d = tmo_q + CNT_W'(1);
        end
      end
      COMMIT: begin
        if (32'(idx_q) < NUM_CHANNELS) begin
          for (int unsigned k = 0; k < NUM_CHANNELS; k++) begin
            if (32'(idx_q) == k) begin
              pulse_d[k]  = clamped_c;
              update_d[k] = 1'b1;
            end
          end
        end else begin
          ferr_d = 1'b1;
        end
        if (i_byte_valid) begin
          idx_d   = i_byte;
          state_d = GET_HI;
        end else begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
    errcnt_d = (ferr_d && errcnt_q != 8'hFF) ? errcnt_q + 8'd1 : errcnt_q;
    busy_d   = (state_d == GET_HI) || (state_d == GET_LO);
  end

  assign o_pulse       = pulse_q;
  assign o_update      = update_q;
  assign o_frame_error = ferr_q;
  assign o_error_count = errcnt_q;
  assign o_busy        = busy_q;

endmodule

// File: tb/tb_servo_cmd_decoder.sv
// Self-checking bench for servo_cmd_decoder against a frame-level reference model.
module tb_servo_cmd_decoder;

  localparam int unsigned NCH = 2;
  localparam int unsigned TMO = 16000;

  logic              clk = 1'b0;
  logic              rst;
  logic              bv;
  logic [7:0]        bt;
  logic              sel;
  logic [16*NCH-1:0] pulse;
  logic [NCH-1:0]    upd;
  logic              ferr;
  logic [7:0]        ecnt;
  logic              busy;
  logic [16*NCH+10:0] obs;

  int unsigned vectors = 0;
  int unsigned miscompares = 0;

  int unsigned    exp_pulse[NCH];
  int unsigned    exp_cnt;
  logic [NCH-1:0] exp_upd;
  logic           exp_ferr;

  servo_cmd_decoder #(
    .NUM_CHANNELS(NCH), .MIN_PULSE(500), .MAX_PULSE(2500),
    .DEFAULT_PULSE(1500), .TIMEOUT_CLKS(TMO)
  ) dut (
    .i_clock(clk), .i_reset(rst), .i_byte_valid(bv), .i_byte(bt), .i_select(sel),
    .o_pulse(pulse), .o_update(upd), .o_frame_error(ferr),
    .o_error_count(ecnt), .o_busy(busy)
  );

  always #5 clk = ~clk;

  assign obs = {pulse, upd, ferr, ecnt};

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_byte(input logic [7:0] b);
    bv = 1'b1;
    bt = b;
    tick();
    bv = 1'b0;
    bt = 8'($urandom);
  endtask

  function automatic int unsigned clampv(input int unsigned v);
    if (v < 500) return 500;
    if (v > 2500) return 2500;
    return v;
  endfunction

  function automatic logic [16*NCH+10:0] exp_obs();
    logic [16*NCH-1:0] p;
    for (int k = 0; k < NCH; k++) p[16*k +: 16] = 16'(exp_pulse[k]);
    return {p, exp_upd, exp_ferr, 8'(exp_cnt)};
  endfunction

  task automatic model_reset();
    for (int k = 0; k < NCH; k++) exp_pulse[k] = 1500;
    exp_cnt  = 0;
    exp_upd  = '0;
    exp_ferr = 1'b0;
  endtask

  task automatic model_error();
    exp_upd  = '0;
    exp_ferr = 1'b1;
    if (exp_cnt < 255) exp_cnt++;
  endtask

  task automatic model_frame(input int unsigned idx, input int unsigned v);
    exp_upd  = '0;
    exp_ferr = 1'b0;
    if (idx < NCH) begin
      exp_pulse[idx] = clampv(v);
      exp_upd[idx]   = 1'b1;
    end else begin
      model_error();
    end
  endtask

  task automatic model_quiet();
    exp_upd  = '0;
    exp_ferr = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; bv = 1'b0; bt = 8'h00; sel = 1'b0;
    tick(); tick();
    rst = 1'b0;
    model_reset();
    vectors++;
    if (obs !== exp_obs() || busy !== 1'b0) begin
      miscompares++;
      $display("FAIL reset_state: got %h busy %b expected %h busy 0", obs, busy, exp_obs());
    end
    // Move ch0 off default, then reset mid-frame with a coincident byte strobe.
    drive_byte(8'h00); drive_byte(8'h09); drive_byte(8'h00);
    model_frame(0, 16'h0900);
    tick();
    vectors++;
    if (obs !== exp_obs()) begin
      miscompares++;
      $display("FAIL reset_preload: got %h expected %h", obs, exp_obs());
    end
    model_quiet();
    drive_byte(8'h01); drive_byte(8'h08);
    vectors++;
    if (busy !== 1'b1) begin
      miscompares++;
      $display("FAIL reset_busy_midframe: got %b expected 1", busy);
    end
    rst = 1'b1; bv = 1'b1; bt = 8'h44;
    tick();
    rst = 1'b0; bv = 1'b0;
    model_reset();
    tick();
    vectors++;
    if (obs !== exp_obs() || busy !== 1'b0) begin
      miscompares++;
      $display("FAIL reset_midframe: got %h busy %b expected %h busy 0", obs, busy, exp_obs());
    end
  endtask

  task automatic test_directed();
    logic [7:0] fr [4][3];
    fr[0] = '{8'h01, 8'h07, 8'hD0};
    fr[1] = '{8'h00, 8'h00, 8'h64};
    fr[2] = '{8'h00, 8'h27, 8'h10};
    fr[3] = '{8'h05, 8'h05, 8'hDC};
    for (int f = 0; f < 4; f++) begin
      drive_byte(fr[f][0]); drive_byte(fr[f][1]); drive_byte(fr[f][2]);
      model_frame(int'(fr[f][0]), int'(fr[f][1]) * 256 + int'(fr[f][2]));
      tick();
      vectors++;
      if (obs !== exp_obs()) begin
        miscompares++;
        $display("FAIL directed_commit[%0d]: got %h expected %h", f, obs, exp_obs());
      end
      model_quiet();
      tick();
      vectors++;
      if (obs !== exp_obs()) begin
        miscompares++;
        $display("FAIL directed_after[%0d]: got %h expected %h", f, obs, exp_obs());
      end
    end
  endtask

  task automatic test_random();
    for (int f = 0; f < 60; f++) begin
      int unsigned idx, v;
      idx = ($urandom_range(0, 9) == 0) ? int'(8'($urandom)) : $urandom_range(0, 2);
      v   = ($urandom_range(0, 3) == 0) ? int'(16'($urandom)) : $urandom_range(0, 3000);
      repeat ($urandom_range(0, 3)) tick();
      drive_byte(8'(idx));
      vectors++;
      if (busy !== 1'b1) begin
        miscompares++;
        $display("FAIL random_busy[%0d]: got %b expected 1", f, busy);
      end
      repeat ($urandom_range(0, 4)) tick();
      drive_byte(8'(v >> 8));
      repeat ($urandom_range(0, 4)) tick();
      drive_byte(8'(v));
      model_frame(idx, v);
      tick();
      vectors++;
      if (obs !== exp_obs()) begin
        miscompares++;
        $display("FAIL random_commit[%0d] idx %0d val %0d: got %h expected %h", f, idx, v, obs, exp_obs());
      end
      model_quiet();
    end
  endtask

  task automatic test_back_to_back();
    for (int f = 0; f < 20; f++) begin
      int unsigned idx, v;
      idx = $urandom_range(0, 2);
      v   = $urandom_range(0, 3000);
      drive_byte(8'(idx));
      if (f > 0) begin
        vectors++;
        if (obs !== exp_obs()) begin
          miscompares++;
          $display("FAIL b2b_commit[%0d]: got %h expected %h", f - 1, obs, exp_obs());
        end
        model_quiet();
      end
      drive_byte(8'(v >> 8));
      vectors++;
      if (obs !== exp_obs() || busy !== 1'b1) begin
        miscompares++;
        $display("FAIL b2b_mid[%0d]: got %h busy %b expected %h busy 1", f, obs, busy, exp_obs());
      end
      drive_byte(8'(v));
      model_frame(idx, v);
    end
    tick();
    vectors++;
    if (obs !== exp_obs()) begin
      miscompares++;
      $display("FAIL b2b_last: got %h expected %h", obs, exp_obs());
    end
    model_quiet();
  endtask

  task automatic test_timeout();
    drive_byte(8'h00);
    repeat (TMO - 2) tick();
    drive_byte(8'h05);
    vectors++;
    if (obs !== exp_obs() || busy !== 1'b1) begin
      miscompares++;
      $display("FAIL timeout_gap_ok: got %h busy %b expected %h busy 1", obs, busy, exp_obs());
    end
    repeat (TMO - 1) tick();
    vectors++;
    if (obs !== exp_obs() || busy !== 1'b1) begin
      miscompares++;
      $display("FAIL timeout_early: got %h busy %b expected %h busy 1", obs, busy, exp_obs());
    end
    tick();
    model_error();
    vectors++;
    if (obs !== exp_obs() || busy !== 1'b0) begin
      miscompares++;
      $display("FAIL timeout_abort: got %h busy %b expected %h busy 0", obs, busy, exp_obs());
    end
    model_quiet();
    tick();
    drive_byte(8'h00); drive_byte(8'h05); drive_byte(8'hDC);
    model_frame(0, 16'h05DC);
    tick();
    vectors++;
    if (obs !== exp_obs()) begin
      miscompares++;
      $display("FAIL timeout_recover: got %h expected %h", obs, exp_obs());
    end
    model_quiet();
  endtask

  task automatic test_deselect();
    // Deselect while idle is harmless.
    sel = 1'b1;
    repeat (4) begin
      tick();
      vectors++;
      if (obs !== exp_obs()) begin
        miscompares++;
        $display("FAIL deselect_idle: got %h expected %h", obs, exp_obs());
      end
    end
    sel = 1'b0;
    repeat (3) tick();
    // Deselect reaching the FSM together with a byte strobe mid-frame.
    drive_byte(8'h01); drive_byte(8'h05);
    sel = 1'b1;
    tick(); tick();
    drive_byte(8'h77);
    model_error();
    vectors++;
    if (obs !== exp_obs() || busy !== 1'b0) begin
      miscompares++;
      $display("FAIL deselect_abort: got %h busy %b expected %h busy 0", obs, busy, exp_obs());
    end
    model_quiet();
    sel = 1'b0;
    repeat (3) tick();
    drive_byte(8'h00); drive_byte(8'h05); drive_byte(8'hDC);
    model_frame(0, 16'h05DC);
    tick();
    vectors++;
    if (obs !== exp_obs()) begin
      miscompares++;
      $display("FAIL deselect_discard: got %h expected %h", obs, exp_obs());
    end
    model_quiet();
    // Deselect landing on the commit cycle lets the commit complete.
    drive_byte(8'h00);
    sel = 1'b1;
    drive_byte(8'h06); drive_byte(8'h40);
    model_frame(0, 16'h0640);
    tick();
    vectors++;
    if (obs !== exp_obs()) begin
      miscompares++;
      $display("FAIL deselect_commit: got %h expected %h", obs, exp_obs());
    end
    model_quiet();
    tick();
    vectors++;
    if (obs !== exp_obs()) begin
      miscompares++;
      $display("FAIL deselect_commit_after: got %h expected %h", obs, exp_obs());
    end
    sel = 1'b0;
    repeat (3) tick();
    // Error counter saturation.
    for (int f = 0; f < 300; f++) begin
      drive_byte(8'h05); drive_byte(8'h05); drive_byte(8'hDC);
      model_frame(5, 16'h05DC);
      tick();
      vectors++;
      if (obs !== exp_obs()) begin
        miscompares++;
        $display("FAIL saturate[%0d]: got %h expected %h", f, obs, exp_obs());
      end
      model_quiet();
    end
    vectors++;
    if (ecnt !== 8'd255) begin
      miscompares++;
      $display("FAIL saturate_final: got %0d expected 255", ecnt);
    end
  endtask

  initial begin
    test_reset();
    test_directed();
    test_random();
    test_back_to_back();
    test_timeout();
    test_deselect();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
